// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side handshake, downstream control and issue-slot bus of the dual-issue scheduler.
// master = fetch/pipeline side driving the scheduler, slave = the scheduler itself.
interface dual_issue_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr1;
    logic [31:0]      in_instr2;
    logic             stall;
    logic             flush;
    logic [31:0]      issue_pc;
    logic [31:0]      issue_instr1;
    logic [31:0]      issue_instr2;
    logic             issue_valid1;
    logic             issue_valid2;
    logic [CNT_W-1:0] split_count;

    modport master (
        output in_valid, in_pc, in_instr1, in_instr2, stall, flush,
        input  in_ready, issue_pc, issue_instr1, issue_instr2,
               issue_valid1, issue_valid2, split_count
    );

    modport slave (
        input  in_valid, in_pc, in_instr1, in_instr2, stall, flush,
        output in_ready, issue_pc, issue_instr1, issue_instr2,
               issue_valid1, issue_valid2, split_count
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Buffers one fetched instruction pair, checks intra-pair hazards and issues it
// either dual or split over two cycles into the ID/EX register.
module dual_issue_scheduler #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   reset_n,
    dual_issue_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_FULL   = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      buf_pc_q, buf_pc_d;
    logic [31:0]      buf_i1_q, buf_i1_d;
    logic [31:0]      buf_i2_q, buf_i2_d;
    logic [31:0]      issue_pc_q, issue_pc_d;
    logic [31:0]      issue_i1_q, issue_i1_d;
    logic [31:0]      issue_i2_q, issue_i2_d;
    logic             issue_v1_q, issue_v1_d;
    logic             issue_v2_q, issue_v2_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    logic [4:0] dst1, dst2;
    logic       mem1, mem2, ctrl1;
    logic       rs2_used, rt2_used;
    logic       raw, waw, dual_ok;
    logic       in_ready, accept;

    // Older instruction: only its destination, memory use and control flow matter.
    always_comb begin
        dst1  = 5'd0;
        mem1  = 1'b0;
        ctrl1 = 1'b0;
        case (buf_i1_q[31:26])
            6'h00: begin
                dst1  = buf_i1_q[15:11];
                ctrl1 = (buf_i1_q[5:0] == 6'h08);
            end
            6'h08, 6'h09, 6'h0C, 6'h0D: dst1 = buf_i1_q[20:16];
            6'h23: begin
                dst1 = buf_i1_q[20:16];
                mem1 = 1'b1;
            end
            6'h2B:                      mem1  = 1'b1;
            6'h02, 6'h04, 6'h05:        ctrl1 = 1'b1;
            6'h03: begin
                dst1  = 5'd31;
                ctrl1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Younger instruction: its sources, destination and memory use.
    always_comb begin
        dst2     = 5'd0;
        mem2     = 1'b0;
        rs2_used = 1'b0;
        rt2_used = 1'b0;
        case (buf_i2_q[31:26])
            6'h00: begin
                dst2     = buf_i2_q[15:11];
                rs2_used = 1'b1;
                rt2_used = 1'b1;
            end
            6'h08, 6'h09, 6'h0C, 6'h0D: begin
                dst2     = buf_i2_q[20:16];
                rs2_used = 1'b1;
            end
            6'h23: begin
                dst2     = buf_i2_q[20:16];
                rs2_used = 1'b1;
                mem2     = 1'b1;
            end
            6'h2B: begin
                rs2_used = 1'b1;
                rt2_used = 1'b1;
                mem2     = 1'b1;
            end
            6'h04, 6'h05: begin
                rs2_used = 1'b1;
                rt2_used = 1'b1;
            end
            6'h03:   dst2 = 5'd31;
            default: ;
        endcase
    end

    assign raw = (dst1 != 5'd0) &&
                 ((rs2_used && (buf_i2_q[25:21] == dst1)) ||
                  (rt2_used && (buf_i2_q[20:16] == dst1)));
    assign waw     = (dst1 != 5'd0) && (dst1 == dst2);
    assign dual_ok = !ctrl1 && !raw && !waw && !(mem1 && mem2);

    assign in_ready = !bus.flush && !bus.stall &&
                      ((state_q == S_EMPTY) || (state_q == S_SECOND) ||
                       ((state_q == S_FULL) && dual_ok));
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else if (!bus.stall) begin
            case (state_q)
                S_FULL:  state_d = !dual_ok ? S_SECOND : (accept ? S_FULL : S_EMPTY);
                default: state_d = accept ? S_FULL : S_EMPTY;
            endcase
        end
    end

    // Stall holds every register; flush and EMPTY both issue a bubble.
    always_comb begin
        issue_pc_d  = issue_pc_q;
        issue_i1_d  = issue_i1_q;
        issue_i2_d  = issue_i2_q;
        issue_v1_d  = issue_v1_q;
        issue_v2_d  = issue_v2_q;
        split_cnt_d = split_cnt_q;
        buf_pc_d    = accept ? bus.in_pc     : buf_pc_q;
        buf_i1_d    = accept ? bus.in_instr1 : buf_i1_q;
        buf_i2_d    = accept ? bus.in_instr2 : buf_i2_q;
        if (bus.flush || (!bus.stall && (state_q != S_FULL) && (state_q != S_SECOND))) begin
            issue_pc_d = 32'd0;
            issue_i1_d = NOP;
            issue_i2_d = NOP;
            issue_v1_d = 1'b0;
            issue_v2_d = 1'b0;
        end else if (!bus.stall && (state_q == S_FULL)) begin
            issue_pc_d = buf_pc_q;
            issue_i1_d = buf_i1_q;
            issue_i2_d = dual_ok ? buf_i2_q : NOP;
            issue_v1_d = 1'b1;
            issue_v2_d = dual_ok;
            if (!dual_ok && (split_cnt_q != {CNT_W{1'b1}}))
                split_cnt_d = split_cnt_q + CNT_ONE;
        end else if (!bus.stall) begin
            issue_pc_d = buf_pc_q + 32'd4;
            issue_i1_d = buf_i2_q;
            issue_i2_d = NOP;
            issue_v1_d = 1'b1;
            issue_v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_pc_q  <= 32'd0;
            issue_i1_q  <= NOP;
            issue_i2_q  <= NOP;
            issue_v1_q  <= 1'b0;
            issue_v2_q  <= 1'b0;
            split_cnt_q <= '0;
            buf_pc_q    <= 32'd0;
            buf_i1_q    <= 32'd0;
            buf_i2_q    <= 32'd0;
        end else begin
            issue_pc_q  <= issue_pc_d;
            issue_i1_q  <= issue_i1_d;
            issue_i2_q  <= issue_i2_d;
            issue_v1_q  <= issue_v1_d;
            issue_v2_q  <= issue_v2_d;
            split_cnt_q <= split_cnt_d;
            buf_pc_q    <= buf_pc_d;
            buf_i1_q    <= buf_i1_d;
            buf_i2_q    <= buf_i2_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.issue_pc     = issue_pc_q;
    assign bus.issue_instr1 = issue_i1_q;
    assign bus.issue_instr2 = issue_i2_q;
    assign bus.issue_valid1 = issue_v1_q;
    assign bus.issue_valid2 = issue_v2_q;
    assign bus.split_count  = split_cnt_q;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Table-driven bench for dual_issue_scheduler: per-cycle vectors with expected
// next-cycle outputs queued on drive and compared when the DUT registers them.
module tb_dual_issue_scheduler;
    localparam int          CW  = 4;  // narrow counter so saturation is reachable quickly
    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [31:0] ADDI1  = 32'h20010005;
    localparam logic [31:0] ADDI1B = 32'h20010007;
    localparam logic [31:0] ADDI3  = 32'h20030007;
    localparam logic [31:0] ADDI0  = 32'h20000005;
    localparam logic [31:0] ADD2   = 32'h00211020;
    localparam logic [31:0] ADDZ   = 32'h00001020;
    localparam logic [31:0] LW     = 32'h8C050000;
    localparam logic [31:0] SW     = 32'hAC060004;
    localparam logic [31:0] SWR1   = 32'hAC010004;
    localparam logic [31:0] BEQ    = 32'h10000002;
    localparam logic [31:0] JAL    = 32'h0C000010;
    localparam logic [31:0] JR     = 32'h03E00008;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dual_issue_scheduler_if #(.CNT_W(CW)) bus ();

    dual_issue_scheduler #(.CNT_W(CW), .NOP(NOP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   i1;
        logic [31:0]   i2;
        logic          v1;
        logic          v2;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        stall;
        logic        flush;
        logic        ready;
        out_t        want;
    } vec_t;

    out_t sb_q[$];
    vec_t tbl[22];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic out_t iss(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                                 input logic v1, input logic v2, input int cnt);
        out_t o;
        o.pc  = pc;
        o.i1  = i1;
        o.i2  = i2;
        o.v1  = v1;
        o.v2  = v2;
        o.cnt = CW'(cnt);
        return o;
    endfunction

    function automatic out_t bub(input int cnt);
        return iss(32'd0, NOP, NOP, 1'b0, 1'b0, cnt);
    endfunction

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic [31:0] i1,
                                input logic [31:0] i2, input logic stall, input logic flush,
                                input logic ready, input out_t want);
        vec_t v;
        v.valid = valid;
        v.pc    = pc;
        v.i1    = i1;
        v.i2    = i2;
        v.stall = stall;
        v.flush = flush;
        v.ready = ready;
        v.want  = want;
        return v;
    endfunction

    // Called at posedge+1: drive, check in_ready at negedge, compare outputs after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        out_t e;
        bus.in_valid  = v.valid;
        bus.in_pc     = v.pc;
        bus.in_instr1 = v.i1;
        bus.in_instr2 = v.i2;
        bus.stall     = v.stall;
        bus.flush     = v.flush;
        sb_q.push_back(v.want);
        #4;
        chk($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(v.ready));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("%s issue_pc", tag),     bus.issue_pc,            e.pc);
        chk($sformatf("%s issue_instr1", tag), bus.issue_instr1,        e.i1);
        chk($sformatf("%s issue_instr2", tag), bus.issue_instr2,        e.i2);
        chk($sformatf("%s issue_valid1", tag), 32'(bus.issue_valid1),   32'(e.v1));
        chk($sformatf("%s issue_valid2", tag), 32'(bus.issue_valid2),   32'(e.v2));
        chk($sformatf("%s split_count", tag),  32'(bus.split_count),    32'(e.cnt));
        $display("tx %s: in v=%b pc=%h st=%b fl=%b rdy=%b -> pc=%h i1=%h i2=%h v=%b%b cnt=%0d",
                 tag, v.valid, v.pc, v.stall, v.flush, v.ready, bus.issue_pc,
                 bus.issue_instr1, bus.issue_instr2, bus.issue_valid1, bus.issue_valid2,
                 bus.split_count);
    endtask

    task automatic check_reset_state(input string tag);
        chk($sformatf("%s issue_pc", tag),     bus.issue_pc,          32'd0);
        chk($sformatf("%s issue_instr1", tag), bus.issue_instr1,      NOP);
        chk($sformatf("%s issue_instr2", tag), bus.issue_instr2,      NOP);
        chk($sformatf("%s issue_valid1", tag), 32'(bus.issue_valid1), 32'd0);
        chk($sformatf("%s issue_valid2", tag), 32'(bus.issue_valid2), 32'd0);
        chk($sformatf("%s split_count", tag),  32'(bus.split_count),  32'd0);
        chk($sformatf("%s in_ready", tag),     32'(bus.in_ready),     32'd1);
        $display("tx %s: pc=%h v=%b%b cnt=%0d", tag, bus.issue_pc,
                 bus.issue_valid1, bus.issue_valid2, bus.split_count);
    endtask

    initial begin
        int prev;
        int cnt;
        // valid, pc, i1, i2, stall, flush, ready, expected outputs after the edge
        tbl[0]  = mk(0, 32'h0,        NOP,   NOP,    0, 0, 1, bub(0));
        tbl[1]  = mk(1, 32'h100,      ADDI1, ADDI3,  0, 0, 1, bub(0));
        tbl[2]  = mk(0, 32'h0,        NOP,   NOP,    0, 0, 1, iss(32'h100, ADDI1, ADDI3, 1, 1, 0));
        tbl[3]  = mk(1, 32'h200,      ADDI1, ADD2,   0, 0, 1, bub(0));
        tbl[4]  = mk(0, 32'h0,        NOP,   NOP,    0, 0, 0, iss(32'h200, ADDI1, NOP, 1, 0, 1));
        tbl[5]  = mk(1, 32'h300,      LW,    SW,     0, 0, 1, iss(32'h204, ADD2, NOP, 1, 0, 1));
        tbl[6]  = mk(1, 32'h400,      BEQ,   ADDI3,  0, 0, 0, iss(32'h300, LW, NOP, 1, 0, 2));
        tbl[7]  = mk(1, 32'h400,      BEQ,   ADDI3,  0, 0, 1, iss(32'h304, SW, NOP, 1, 0, 2));
        tbl[8]  = mk(1, 32'h500,      ADDI1, ADDI3,  0, 0, 0, iss(32'h400, BEQ, NOP, 1, 0, 3));
        tbl[9]  = mk(1, 32'h500,      ADDI1, ADDI3,  0, 0, 1, iss(32'h404, ADDI3, NOP, 1, 0, 3));
        tbl[10] = mk(1, 32'h600,      LW,    ADDI3,  0, 0, 1, iss(32'h500, ADDI1, ADDI3, 1, 1, 3));
        tbl[11] = mk(1, 32'h700,      ADDI0, ADDZ,   0, 0, 1, iss(32'h600, LW, ADDI3, 1, 1, 3));
        tbl[12] = mk(1, 32'h800,      ADDI1, ADDI1B, 0, 0, 1, iss(32'h700, ADDI0, ADDZ, 1, 1, 3));
        tbl[13] = mk(0, 32'h0,        NOP,   NOP,    0, 0, 0, iss(32'h800, ADDI1, NOP, 1, 0, 4));
        tbl[14] = mk(1, 32'hFFFFFFFC, JAL,   ADDI3,  0, 0, 1, iss(32'h804, ADDI1B, NOP, 1, 0, 4));
        tbl[15] = mk(1, 32'h900,      JR,    ADDI3,  0, 0, 0, iss(32'hFFFFFFFC, JAL, NOP, 1, 0, 5));
        tbl[16] = mk(1, 32'h900,      JR,    ADDI3,  0, 0, 1, iss(32'h0, ADDI3, NOP, 1, 0, 5));
        tbl[17] = mk(1, 32'hA00,      ADDI1, SWR1,   0, 0, 0, iss(32'h900, JR, NOP, 1, 0, 6));
        tbl[18] = mk(1, 32'hA00,      ADDI1, SWR1,   0, 0, 1, iss(32'h904, ADDI3, NOP, 1, 0, 6));
        tbl[19] = mk(0, 32'h0,        NOP,   NOP,    0, 0, 0, iss(32'hA00, ADDI1, NOP, 1, 0, 7));
        tbl[20] = mk(0, 32'h0,        NOP,   NOP,    0, 0, 1, iss(32'hA04, SWR1, NOP, 1, 0, 7));
        tbl[21] = mk(0, 32'h0,        NOP,   NOP,    0, 0, 1, bub(7));

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_instr1 = 32'd0;
        bus.in_instr2 = 32'd0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++)
            run_vec($sformatf("row%0d", i), tbl[i]);

        // Stall while the second half of a split pair is pending.
        run_vec("stall_acc", mk(1, 32'hB00, ADDI1, ADD2, 0, 0, 1, bub(7)));
        run_vec("stall_i1",  mk(0, 32'h0, NOP, NOP, 0, 0, 0, iss(32'hB00, ADDI1, NOP, 1, 0, 8)));
        for (int k = 0; k < 3; k++)
            run_vec($sformatf("stall_hold%0d", k),
                    mk(1, 32'hC00, ADDI1, ADDI3, 1, 0, 0, iss(32'hB00, ADDI1, NOP, 1, 0, 8)));
        run_vec("stall_rel", mk(0, 32'h0, NOP, NOP, 0, 0, 1, iss(32'hB04, ADD2, NOP, 1, 0, 8)));
        run_vec("stall_end", mk(0, 32'h0, NOP, NOP, 0, 0, 1, bub(8)));

        // Flush in SECOND drops pending instr2 and the offered pair.
        run_vec("flush_acc", mk(1, 32'hD00, ADDI1, ADD2, 0, 0, 1, bub(8)));
        run_vec("flush_i1",  mk(0, 32'h0, NOP, NOP, 0, 0, 0, iss(32'hD00, ADDI1, NOP, 1, 0, 9)));
        run_vec("flush_sec", mk(1, 32'hE00, ADDI1, ADDI3, 0, 1, 0, bub(9)));
        run_vec("flush_aft", mk(0, 32'h0, NOP, NOP, 0, 0, 1, bub(9)));
        // Flush beats stall in FULL.
        run_vec("fs_acc",    mk(1, 32'hF00, ADDI1, ADD2, 0, 0, 1, bub(9)));
        run_vec("fs_both",   mk(1, 32'hF80, ADDI1, ADDI3, 1, 1, 0, bub(9)));
        run_vec("fs_aft",    mk(0, 32'h0, NOP, NOP, 0, 0, 1, bub(9)));

        // Asynchronous reset between edges while a pair sits in FULL.
        run_vec("rst_acc1",  mk(1, 32'h1100, ADDI1, ADDI3, 0, 0, 1, bub(9)));
        run_vec("rst_acc2",  mk(1, 32'h1200, LW, ADDI3, 0, 0, 1, iss(32'h1100, ADDI1, ADDI3, 1, 1, 9)));
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec("rst_aft1",  mk(0, 32'h0, NOP, NOP, 0, 0, 1, bub(0)));
        run_vec("rst_aft2",  mk(0, 32'h0, NOP, NOP, 0, 0, 1, bub(0)));

        // Split-counter saturation at all-ones.
        prev = 0;
        for (int k = 0; k < 17; k++) begin
            cnt = (prev == (1 << CW) - 1) ? prev : prev + 1;
            run_vec($sformatf("sat%0d_acc", k), mk(1, 32'h2000, ADDI1, ADD2, 0, 0, 1, bub(prev)));
            run_vec($sformatf("sat%0d_i1", k),
                    mk(0, 32'h0, NOP, NOP, 0, 0, 0, iss(32'h2000, ADDI1, NOP, 1, 0, cnt)));
            run_vec($sformatf("sat%0d_i2", k),
                    mk(0, 32'h0, NOP, NOP, 0, 0, 1, iss(32'h2004, ADD2, NOP, 1, 0, cnt)));
            prev = cnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
Issue-pair scheduler in front of the dual-issue ID/EX register of the superscalar MIPS pipeline. It buffers one fetched instruction pair and checks for intra-pair hazards: RAW, WAW, structural (single memory port) and control (slot-1 branch/jump). It then issues either both instructions in one cycle or splits them across two cycles, with NOP padding. It honours a downstream stall and a branch flush, and keeps a saturating count of split pairs.

Parameters:
CNT_W, 16, width of the split-pair statistics counter
NOP, 32'h0000_0000, encoding driven into an empty issue slot

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch offers a pair
in_ready  output  1  scheduler accepts the pair this cycle
in_pc  input  32  PC of in_instr1; in_instr2 is at in_pc+4
in_instr1  input  32  older instruction
in_instr2  input  32  younger instruction
stall  input  1  downstream hold (load-use or EX busy)
flush  input  1  redirect; discard everything buffered
issue_pc  output  32  PC of issue_instr1
issue_instr1  output  32  slot-1 instruction to ID/EX register
issue_instr2  output  32  slot-2 instruction to ID/EX register
issue_valid1  output  1  slot 1 holds a real instruction
issue_valid2  output  1  slot 2 holds a real instruction
split_count  output  CNT_W  number of pairs issued split, saturating

Behaviour:
- Reset (reset_n low, async): state EMPTY; issue_pc=0; issue_instr1=issue_instr2=NOP; issue_valid1=issue_valid2=0; split_count=0; buffer cleared.
- All issue_* outputs are registered. in_ready is combinational.
- Decode rules (opcode [31:26]):
  - R-type (op 0): dest = rd [15:11]; sources rs, rt.
  - addi/addiu/andi/ori (8/9/C/D): dest = rt; source rs.
  - lw (23): dest = rt; source rs; mem op.
  - sw (2B): no dest; sources rs, rt; mem op.
  - beq/bne (4/5): no dest; sources rs, rt; control.
  - j (2): control. jal (3): control, dest = 31.
  - R-type funct 08 (jr): control.
  - Any other opcode: no dest, no sources, not mem, not control.
  - Register 0 is never a hazard dest.
- dual_ok is 1 only if all of the following hold:
  - instr1 is not control;
  - instr1 dest (nonzero) matches no instr2 source;
  - instr1 dest does not equal instr2 dest (nonzero);
  - instr1 and instr2 are not both mem ops.
- States: EMPTY (no pair held), FULL (pair held, nothing issued), SECOND (instr1 issued, instr2 pending).
- Priority per edge: reset > flush > stall > normal.
- flush: state goes to EMPTY, outputs become a bubble (NOP, valids 0), in_ready=0 that cycle, the incoming pair is dropped.
- stall (no flush): outputs, state, buffer and counter are all held; in_ready=0.
- Normal cycle:
  - EMPTY: issue a bubble.
  - FULL with dual_ok: issue buf_pc, i1, i2, valids 1/1.
  - FULL without dual_ok: issue buf_pc, i1, NOP, valids 1/0; state goes to SECOND; split_count increments (saturating at all-ones).
  - SECOND: issue buf_pc+4, i2, NOP, valids 1/0.
- in_ready = !flush && !stall && (EMPTY || SECOND || (FULL && dual_ok)).
- Accept (in_valid && in_ready): load the buffer and set the next state to FULL. Otherwise the next state after an EMPTY, SECOND or dual-issued FULL cycle is EMPTY.
- Latency: a pair accepted at edge E is issued at edge E+1. Sustained throughput is one pair per cycle when dual_ok.
- PC arithmetic is modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Reset asserted mid-split discards the pending instr2.

Test Plan:
- Independent pair: pc=0x100, i1=0x20010005 (addi $1,$0,5), i2=0x20030007 (addi $3,$0,7) -> next cycle issue_pc=0x100, both instrs, valids 1/1; split_count=0.
- RAW: i1=0x20010005, i2=0x00211020 (add $2,$1,$1), pc=0x200 -> cycle1: 0x200/0x20010005/NOP, valids 1/0; cycle2: 0x204/0x00211020/NOP; split_count=1; in_ready=0 in cycle1, 1 in cycle2.
- Structural and control: i1=0x8C050000 (lw), i2=0xAC060004 (sw) -> split. Then i1=0x10000002 (beq), i2=0x20030007 -> split. split_count=2.
- Stall in SECOND for 3 cycles -> outputs and in_ready frozen, split_count unchanged; after release, 0x204 issues exactly once.
- Flush during SECOND with in_valid=1 -> next outputs are a bubble, pending instr2 is never issued, the offered pair is not accepted, state is EMPTY.
- Async reset_n pulse mid-FULL (between edges) -> all outputs 0/NOP immediately; split_count saturation check: preload to 0xFFFF, then a split keeps it at 0xFFFF.
